// File: rtl/inst_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue_if
// Description : Handshake bundle between the fetch/decode environment and the
//               instruction fetch queue.
//   push_i / pc_i / inst_i : fetched instruction entering the queue
//   flush_i                : discard every queued entry (taken branch)
//   ready_i                : decode accepts the head entry
//   valid_o / pc_o / inst_o: head entry presented to decode
//   full_o                 : stall request to fetch
//   count_o                : number of occupied entries
//   overflow_o             : sticky "a push was dropped" flag
//   Modport master: the fetch/decode side.  Modport slave: the queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push_i;
  logic [ADDR_W-1:0] pc_i;
  logic [DATA_W-1:0] inst_i;
  logic              flush_i;
  logic              ready_i;
  logic              valid_o;
  logic [ADDR_W-1:0] pc_o;
  logic [DATA_W-1:0] inst_o;
  logic              full_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;

  modport master (
    output push_i, pc_i, inst_i, flush_i, ready_i,
    input  valid_o, pc_o, inst_o, full_o, count_o, overflow_o
  );

  modport slave (
    input  push_i, pc_i, inst_i, flush_i, ready_i,
    output valid_o, pc_o, inst_o, full_o, count_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue
// Description : First-word-fall-through instruction fetch queue. Holds DEPTH
//               {pc, inst} entries in a circular buffer, presents the oldest
//               entry to decode, raises full as a fetch stall, and discards
//               everything on flush.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : inst_queue_if.slave (push/flush/ready in, head/full/count/overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4   // power of two, >= 2
) (
  input  logic          clk,
  input  logic          rst,
  inst_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Storage is deliberately not reset; the head registers below carry the
  // visible output so nothing unwritten ever reaches decode.
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              overflow;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_inst;

  logic valid;
  logic full;
  logic pop;
  logic push_ok;
  logic drop;
  logic head_from_input;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign pop     = valid & bus.ready_i & ~bus.flush_i;
  // A full queue still takes a push when decode frees a slot in the same cycle.
  assign push_ok = bus.push_i & ~bus.flush_i & (~full | pop);
  assign drop    = bus.push_i & ~bus.flush_i & full & ~pop;

  assign rd_ptr_nxt = pop ? (rd_ptr + 1'b1) : rd_ptr;

  // The incoming word becomes the new head when it lands in the slot the read
  // pointer will point at: empty queue, or a single entry being popped.
  assign head_from_input = push_ok & (rd_ptr_nxt == wr_ptr);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr]   <= bus.pc_i;
      inst_mem[wr_ptr] <= bus.inst_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      head_pc   <= '0;
      head_inst <= '0;
    end else if (bus.flush_i) begin
      // Flush leaves overflow and the (now ignored) head value untouched.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (drop) begin
        overflow <= 1'b1;
      end
      // Head only reloads while something is queued, so an emptied queue
      // keeps showing its last entry.
      if (count_nxt != '0) begin
        if (head_from_input) begin
          head_pc   <= bus.pc_i;
          head_inst <= bus.inst_i;
        end else begin
          head_pc   <= pc_mem[rd_ptr_nxt];
          head_inst <= inst_mem[rd_ptr_nxt];
        end
      end
    end
  end

  assign bus.valid_o    = valid;
  assign bus.pc_o       = head_pc;
  assign bus.inst_o     = head_inst;
  assign bus.full_o     = full;
  assign bus.count_o    = count;
  assign bus.overflow_o = overflow;

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_inst_queue
// Description : Self-checking bench for inst_queue. A vector table drives the
//               fill/drain/wrap/full/overflow/flush sequences; a queue
//               scoreboard holds the expected entries and is compared at
//               every pop and against the head after every edge. Reset is
//               exercised by hand, including a mid-cycle assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 4;

  typedef struct {
    logic              push;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              ready;
    int                exp_count;
    logic              exp_full;
    logic              exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inst_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  inst_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  entry_t sb[$];
  entry_t last_head;
  logic   m_ovf;
  vec_t   vecs[$];
  int     n_cmp  = 0;
  int     n_fail = 0;

  function automatic logic [DATA_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
    return {pc, 7'h35, ~pc[7:0], 8'h5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic push, input logic [ADDR_W-1:0] pc, input logic flush,
                     input logic ready, input int exp_count, input logic exp_full,
                     input logic exp_ovf);
    vec_t v;
    v.push = push; v.pc = pc; v.flush = flush; v.ready = ready;
    v.exp_count = exp_count; v.exp_full = exp_full; v.exp_ovf = exp_ovf;
    vecs.push_back(v);
  endtask

  // Called just after an edge: drives one cycle of inputs, updates the
  // scoreboard, waits for the next edge and checks the registered outputs.
  task automatic step(input logic push, input logic [ADDR_W-1:0] pc,
                      input logic flush, input logic ready);
    logic   m_full;
    logic   m_pop;
    entry_t e;
    bus.push_i  = push;
    bus.pc_i    = pc;
    bus.inst_i  = inst_of(pc);
    bus.flush_i = flush;
    bus.ready_i = ready;
    m_full = (sb.size() == DEPTH);
    m_pop  = (sb.size() != 0) && ready && !flush;
    if (m_pop) begin
      e = sb.pop_front();
      check("pop_pc", 64'(bus.pc_o), 64'(e.pc));
      check("pop_inst", 64'(bus.inst_o), 64'(e.inst));
    end
    if (flush) begin
      sb.delete();
    end else if (push && (!m_full || m_pop)) begin
      e.pc   = pc;
      e.inst = inst_of(pc);
      sb.push_back(e);
    end else if (push) begin
      m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) last_head = sb[0];
    check("count", 64'(bus.count_o), 64'(sb.size()));
    check("valid", 64'(bus.valid_o), 64'(sb.size() != 0));
    check("full", 64'(bus.full_o), 64'(sb.size() == DEPTH));
    check("overflow", 64'(bus.overflow_o), 64'(m_ovf));
    check("head_pc", 64'(bus.pc_o), 64'(last_head.pc));
    check("head_inst", 64'(bus.inst_o), 64'(last_head.inst));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.push_i = 1'b0; bus.pc_i = '0; bus.inst_i = '0;
    bus.flush_i = 1'b0; bus.ready_i = 1'b0;
    sb.delete();
    last_head = '0;
    m_ovf = 1'b0;

    // Fill to full with decode stalled.
    for (int i = 0; i < 4; i++) add(1'b1, 9'(i), 1'b0, 1'b0, i + 1, (i == 3), 1'b0);
    // Drain in order.
    for (int i = 0; i < 4; i++) add(1'b0, 9'h0, 1'b0, 1'b1, 3 - i, 1'b0, 1'b0);
    // Streaming: both pointers wrap twice, occupancy held at 1.
    for (int i = 0; i < 10; i++) add(1'b1, 9'(i), 1'b0, 1'b1, 1, 1'b0, 1'b0);
    add(1'b0, 9'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    // Refill, then push and pop together while full.
    for (int i = 0; i < 4; i++) add(1'b1, 9'(12 + i), 1'b0, 1'b0, i + 1, (i == 3), 1'b0);
    add(1'b1, 9'h010, 1'b0, 1'b1, 4, 1'b1, 1'b0);
    // Overflow: push into full with no pop, then check stickiness.
    add(1'b1, 9'h0FF, 1'b0, 1'b0, 4, 1'b1, 1'b1);
    add(1'b0, 9'h0, 1'b0, 1'b0, 4, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b0, 9'h0, 1'b0, 1'b1, 3 - i, 1'b0, 1'b1);
    // Flush with push and ready at count 3, then a fresh head.
    for (int i = 0; i < 3; i++) add(1'b1, 9'(21 + i), 1'b0, 1'b0, i + 1, 1'b0, 1'b1);
    add(1'b1, 9'h0AA, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    add(1'b1, 9'h020, 1'b0, 1'b0, 1, 1'b0, 1'b1);

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_full", 64'(bus.full_o), 64'd0);
    check("rst_overflow", 64'(bus.overflow_o), 64'd0);
    check("rst_pc", 64'(bus.pc_o), 64'd0);
    check("rst_inst", 64'(bus.inst_o), 64'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].push, vecs[k].pc, vecs[k].flush, vecs[k].ready);
      check("tbl_count", 64'(bus.count_o), 64'(vecs[k].exp_count));
      check("tbl_full", 64'(bus.full_o), 64'(vecs[k].exp_full));
      check("tbl_overflow", 64'(bus.overflow_o), 64'(vecs[k].exp_ovf));
    end
    check("flush_new_head", 64'(bus.pc_o), 64'h020);

    // Asynchronous reset between edges, with push still asserted.
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.valid_o), 64'd0);
    check("arst_overflow", 64'(bus.overflow_o), 64'd0);
    check("arst_count", 64'(bus.count_o), 64'd0);
    check("arst_pc", 64'(bus.pc_o), 64'd0);
    check("arst_inst", 64'(bus.inst_o), 64'd0);
    sb.delete();
    m_ovf = 1'b0;
    last_head = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 9'h030, 1'b0, 1'b0);
    step(1'b0, 9'h000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/inst_queue.md
# inst_queue

Instruction fetch queue sitting between the instruction memory (addressed by the fetch stage's PC) and the decode stage. It captures each fetched instruction with its PC in a small FIFO, presents the oldest entry to decode with a valid/ready handshake, and raises a full flag that the fetch stage uses as a stall. A flush input discards all queued instructions when a taken branch redirects the PC.

## Interface
- DATA_W, 32, instruction width (`datawidth`)
- ADDR_W, 9, PC width (`im_addr_width`)
- DEPTH, 4, number of entries; power of two, at least 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- push_i  input  1  instruction memory output is valid this cycle
- pc_i  input  ADDR_W  PC of the incoming instruction
- inst_i  input  DATA_W  incoming instruction word
- flush_i  input  1  discard all entries; also discards a push in the same cycle
- ready_i  input  1  decode accepts the head entry this cycle
- valid_o  output  1  head entry is valid
- pc_o  output  ADDR_W  PC of the head entry
- inst_o  output  DATA_W  head instruction word
- full_o  output  1  count == DEPTH; stall request to fetch
- count_o  output  log2(DEPTH)+1  number of occupied entries
- overflow_o  output  1  sticky flag: a push was dropped

## Operation
- Storage is a circular buffer of DEPTH {pc, inst} entries with read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits. Both pointers wrap modulo DEPTH. An occupancy counter count (log2(DEPTH)+1 bits) is kept separately.
- The queue is first-word-fall-through. valid_o = (count != 0). pc_o and inst_o always show the entry at rd_ptr. When count == 0, pc_o and inst_o hold their last value, and decode must ignore them.
- pop = valid_o & ready_i & ~flush_i.
- push_ok = push_i & ~flush_i & (~full_o | pop). A push into a full queue is accepted only when a pop happens in the same cycle.
- drop = push_i & ~flush_i & full_o & ~pop. When drop occurs, the entry is discarded, overflow_o is set, and no pointer or count changes.
- flush_i has the highest priority. It sets rd_ptr = wr_ptr = 0 and count = 0. It ignores ready_i and push_i, and it leaves overflow_o unchanged.
- On push_ok, the entry at wr_ptr is written and wr_ptr increments. On pop, rd_ptr increments. count changes by +1 for push only, −1 for pop only, and 0 when both occur.
- overflow_o is cleared only by rst.
- full_o = (count == DEPTH). It is decoded from registered count, with no combinational path from any input.

## Timing
- On rst assertion, without waiting for a clock edge: count = 0, rd_ptr = wr_ptr = 0, valid_o = 0, full_o = 0, count_o = 0, overflow_o = 0, pc_o = 0, inst_o = 0. The storage array does not need to be reset, but the output mux must read 0 while the queue is empty after reset.
- Reset is asserted asynchronously and releases on the clock; the first push is accepted on the first rising edge at which rst is low.
- Latency: a push accepted at edge N into an empty queue gives valid_o = 1 with that entry's pc_o and inst_o immediately after edge N. There is no same-cycle bypass from push_i to valid_o.
- Throughput: one push and one pop per cycle in every state, including full, with count held constant.
- full_o rises immediately after the edge that makes count = DEPTH. Fetch stalls starting in the next cycle, so any in-flight push in that cycle is dropped unless decode pops.
- flush_i asserted at edge N gives valid_o = 0 immediately after edge N. A push presented together with the flush is lost and does not set overflow_o.
- Reset in the middle of operation clears all state asynchronously, regardless of push_i, flush_i or ready_i.

## Test plan
- Reset and fill: after rst, check valid_o = 0 and count_o = 0. Push pc 0x000..0x003 with ready_i = 0 → count_o steps 1,2,3,4, full_o = 1 after the 4th edge, and the head stays at pc_o = 0x000.
- Drain and order: from full, hold ready_i = 1 for 4 cycles → pc_o sequence 0x000, 0x001, 0x002, 0x003, then valid_o = 0 and full_o = 0.
- Pointer wrap: stream 10 pushes with ready_i = 1 every cycle → count_o stays at 1 after the first edge, and the outputs track pc 0x000..0x009 one cycle delayed. Both pointers wrap twice with no data loss.
- Full with simultaneous push and pop: at count 4, push pc 0x010 with ready_i = 1 → count_o stays 4, overflow_o stays 0, and 0x010 appears after the 3 older entries.
- Overflow: at count 4, push with ready_i = 0 → overflow_o = 1 and sticky, count_o = 4, and the contents are unchanged.
- Flush and reset: at count 3, assert flush_i together with push_i and ready_i → valid_o = 0 and count_o = 0 after the edge, and the next push (pc 0x020) becomes the head. Asserting rst between clock edges clears valid_o and overflow_o immediately.
